irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- CSR-mapped interrupt controller between the SoC's interrupt sources (minimac2 irq_rx/irq_tx, UART, sysctl timers) and the 32-bit lm32 `interrupt` input, which is currently tied to zero.
- Per source it provides edge or level capture, pending latch, mask, and a lowest-index priority ID register.
- It sits on the csrbrg CSR bus alongside gpio, uart, sysctl and minimac2, and drives csr_do into the shared OR.

Parameters:
- csr_addr, 4'h4, CSR bank select; matched against csr_a[13:10].
- NIRQ, 8, number of sources (1..32); cpu_irq bits [31:NIRQ] are tied to 0.
- SYNC, 0, 1 = insert a 2-flop synchronizer on each irq_in bit; 0 = sample irq_in directly.
- EDGE_RESET, 0, reset value of the EDGE mode register (NIRQ bits).

Ports:
- sys_clk, input, 1, system clock; all logic on its rising edge.
- sys_rst, input, 1, reset; synchronous, active-high.
- csr_a, input, 14, CSR address.
- csr_we, input, 1, CSR write strobe.
- csr_di, input, 32, CSR write data.
- csr_do, output, 32, CSR read data; 0 when the bank is not selected.
- irq_in, input, NIRQ, raw interrupt sources, active-high.
- cpu_irq, output, 32, to lm32 interrupt: (pending & mask), zero-extended.

Behaviour:
- Bank select: sel = (csr_a[13:10] == csr_addr). Register index = csr_a[2:0]; csr_a[9:3] is ignored.
- raw = irq_in (SYNC=0) or the output of the 2-flop synchronizer (SYNC=1). prev <= raw every cycle, including during reset, so a source held high through reset produces no spurious edge.
- Register map (bits >= NIRQ read 0, writes ignored):
  - 0 PENDING: read pending. Write 1 to clear, edge-mode bits only.
  - 1 MASK: R/W.
  - 2 EDGE: R/W; 1 = rising-edge mode, 0 = level mode.
  - 3 RAW: read-only raw.
  - 4 ID: read-only; bit31 = valid = |(pending & mask); bits[4:0] = lowest set index of (pending & mask), 0 when not valid.
  - 5..7: read 0, writes ignored.
- Pending update per bit i, each cycle:
  - Level mode: pending[i] <= raw[i]. A write to PENDING has no effect.
  - Edge mode: pending[i] <= (raw[i] & ~prev[i]) | (pending[i] & ~w1c[i]), where w1c = sel & csr_we & index==0 & csr_di. A new edge and a W1C in the same cycle leaves the bit set (set wins).
- Writing EDGE clears pending for every bit whose mode changes, in the same cycle the new EDGE value loads.
- cpu_irq is registered: cpu_irq <= {zeros, pending & mask}.
- Latency, SYNC=0: irq_in rises before edge k; pending is visible after edge k; cpu_irq is visible after edge k+1. SYNC=1 adds 2 cycles.
- MASK or W1C write at edge k: pending reflects it after edge k; cpu_irq reflects it after edge k+1.
- CSR read: csr_do <= sel ? reg[index] : 32'd0. Data is valid the cycle after the address is presented. A read and write to the same register in one cycle returns the old value.
- Reset, synchronous, while sys_rst=1 at a clock edge:
  - pending=0, mask=0, EDGE=EDGE_RESET, csr_do=0, cpu_irq=0.
  - Synchronizer flops are cleared; prev is not.
  - Reset asserted mid-interrupt drops cpu_irq after that edge.
  - A level source still high after reset re-asserts pending on the first edge after sys_rst falls.

Test Plan:
1. Reset, NIRQ=8, SYNC=0: assert sys_rst 2 cycles with irq_in=8'hFF → cpu_irq=0, csr_do=0, every register reads 0 (EDGE reads EDGE_RESET). After release with MASK=0, PENDING reads 8'hFF (level mode) and cpu_irq stays 0.
2. Edge capture: EDGE=8'h01, MASK=8'h01. Pulse irq_in[0] for 1 cycle → PENDING=1, cpu_irq=32'h1 two edges after the rise, held after the input falls. Write 1 to PENDING → cpu_irq=0 two edges later.
3. Set-wins collision: in edge mode, a W1C of bit 0 in the same cycle as a new rising edge on irq_in[0] → PENDING[0] stays 1.
4. Level mode: MASK=8'h02, hold irq_in[1]=1 → cpu_irq=32'h2. A W1C of bit 1 has no effect. Drop irq_in[1] → cpu_irq=0 two edges later.
5. Priority ID: pending=8'h28, MASK=8'hFF → ID reads 32'h8000_0003. Then MASK=8'h20 → 32'h8000_0005. Then MASK=0 → 32'h0.
6. Bank decode and mode switch: a read with csr_a[13:10]≠4 → csr_do=0. Write EDGE 0→1 on bit 2 while PENDING[2]=1 → PENDING[2]=0. Write to index 6 → no register changes.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: CSR-mapped interrupt controller with per-source edge/level capture,
// pending latch, mask and lowest-index priority ID, driving the lm32 interrupt vector.
module irq_ctrl #(
    parameter logic [3:0]      csr_addr   = 4'h4,
    parameter int              NIRQ       = 8,
    parameter bit              SYNC       = 1'b0,
    parameter logic [NIRQ-1:0] EDGE_RESET = '0
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [13:0]     csr_a,
    input  logic            csr_we,
    input  logic [31:0]     csr_di,
    output logic [31:0]     csr_do,
    input  logic [NIRQ-1:0] irq_in,
    output logic [31:0]     cpu_irq
);
    logic [NIRQ-1:0] raw, prev, pending, mask, edge_mode, masked, w1c, mode_chg, pending_nx, wdata;
    logic [2:0]      idx;
    logic            sel, wr, valid;
    logic [4:0]      id_idx;
    logic [31:0]     rd_data;
    logic            unused_bits;

    if (SYNC) begin : g_sync
        logic [NIRQ-1:0] s1, s2;
        always_ff @(posedge sys_clk) begin
            s1 <= sys_rst ? '0 : irq_in;
            s2 <= sys_rst ? '0 : s1;
        end
        assign raw = s2;
    end else begin : g_direct
        assign raw = irq_in;
    end

    assign unused_bits = ^{csr_a[9:3], csr_di};
    assign sel         = csr_a[13:10] == csr_addr;
    assign idx         = csr_a[2:0];
    assign wr          = sel & csr_we;
    assign wdata       = csr_di[NIRQ-1:0];
    assign w1c         = (wr && idx == 3'd0) ? wdata : '0;
    assign mode_chg    = (wr && idx == 3'd2) ? (wdata ^ edge_mode) : '0;
    // a mode switch discards whatever was captured under the old mode
    assign pending_nx  = ((edge_mode & ((raw & ~prev) | (pending & ~w1c))) | (~edge_mode & raw)) & ~mode_chg;
    assign masked      = pending & mask;
    assign valid       = |masked;

    always_comb begin
        id_idx = 5'd0;
        for (int i = NIRQ - 1; i >= 0; i--)
            if (masked[i]) id_idx = 5'(i);
    end

    assign rd_data = !sel        ? 32'd0 :
                     idx == 3'd0 ? 32'(pending) :
                     idx == 3'd1 ? 32'(mask) :
                     idx == 3'd2 ? 32'(edge_mode) :
                     idx == 3'd3 ? 32'(raw) :
                     idx == 3'd4 ? {valid, 26'd0, id_idx} : 32'd0;

    // prev tracks raw through reset so a source held high gives no edge on release
    always_ff @(posedge sys_clk)
        prev <= raw;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pending   <= '0;
            mask      <= '0;
            edge_mode <= EDGE_RESET;
            csr_do    <= '0;
            cpu_irq   <= '0;
        end else begin
            pending   <= pending_nx;
            mask      <= (wr && idx == 3'd1) ? wdata : mask;
            edge_mode <= (wr && idx == 3'd2) ? wdata : edge_mode;
            csr_do    <= rd_data;
            cpu_irq   <= 32'(masked);
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed-vector bench for irq_ctrl (NIRQ=8, SYNC=0, EDGE_RESET=0).
module tb_irq_ctrl;
    localparam logic [3:0] BANK = 4'h4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] csr_a = '0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_di = '0;
    logic [31:0] csr_do;
    logic [7:0]  irq_in = 8'hFF;
    logic [31:0] cpu_irq;
    logic [31:0] rdata;
    int          errors = 0;
    int          checks = 0;

    irq_ctrl #(.csr_addr(BANK), .NIRQ(8), .SYNC(1'b0), .EDGE_RESET(8'h00)) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .csr_a(csr_a),
        .csr_we(csr_we),
        .csr_di(csr_di),
        .csr_do(csr_do),
        .irq_in(irq_in),
        .cpu_irq(cpu_irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d);
        csr_a  = {BANK, 7'd0, idx};
        csr_di = d;
        csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] idx, output logic [31:0] d);
        csr_a = {BANK, 7'd0, idx};
        tick();
        d = csr_do;
    endtask

    initial begin
        tick();
        tick();
        check("rst_cpu_irq", cpu_irq, 32'h0);
        check("rst_csr_do", csr_do, 32'h0);
        rst = 1'b0;
        rd(3'd0, rdata); check("pend_reset_val", rdata, 32'h0);
        rd(3'd0, rdata); check("pend_level_ff", rdata, 32'hFF);
        rd(3'd1, rdata); check("mask_reset", rdata, 32'h0);
        rd(3'd2, rdata); check("edge_reset", rdata, 32'h0);
        rd(3'd3, rdata); check("raw_ff", rdata, 32'hFF);
        rd(3'd4, rdata); check("id_reset", rdata, 32'h0);
        check("cpu_irq_masked", cpu_irq, 32'h0);

        irq_in = 8'h00;
        tick();
        wr(3'd2, 32'h01);
        wr(3'd1, 32'h01);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        check("edge_lat_k", cpu_irq, 32'h0);
        tick();
        check("edge_lat_k1", cpu_irq, 32'h1);
        tick();
        tick();
        check("edge_held", cpu_irq, 32'h1);
        rd(3'd0, rdata); check("edge_pend", rdata, 32'h1);
        wr(3'd0, 32'h01);
        check("w1c_lat_k", cpu_irq, 32'h1);
        tick();
        check("w1c_lat_k1", cpu_irq, 32'h0);

        irq_in = 8'h01;
        wr(3'd0, 32'h01);
        rd(3'd0, rdata); check("set_wins", rdata, 32'h1);
        irq_in = 8'h00;
        wr(3'd0, 32'h01);
        tick();
        check("set_wins_clr", cpu_irq, 32'h0);

        wr(3'd2, 32'h00);
        wr(3'd1, 32'h02);
        irq_in = 8'h02;
        tick();
        tick();
        check("level_on", cpu_irq, 32'h2);
        wr(3'd0, 32'h02);
        check("level_w1c_irq", cpu_irq, 32'h2);
        rd(3'd0, rdata); check("level_w1c_pend", rdata, 32'h2);
        irq_in = 8'h00;
        tick();
        check("level_off_k", cpu_irq, 32'h2);
        tick();
        check("level_off_k1", cpu_irq, 32'h0);

        irq_in = 8'h28;
        wr(3'd1, 32'hFF);
        rd(3'd4, rdata); check("id_3", rdata, 32'h8000_0003);
        wr(3'd1, 32'h20);
        rd(3'd4, rdata); check("id_5", rdata, 32'h8000_0005);
        check("cpu_irq_20", cpu_irq, 32'h20);
        wr(3'd1, 32'h00);
        rd(3'd4, rdata); check("id_none", rdata, 32'h0);

        csr_a = {4'h3, 7'd0, 3'd3};
        tick();
        check("bank_miss", csr_do, 32'h0);
        csr_a = {BANK, 7'h55, 3'd3};
        tick();
        check("bank_alias_raw", csr_do, 32'h28);
        irq_in = 8'h04;
        tick();
        rd(3'd0, rdata); check("pend2_level", rdata, 32'h04);
        wr(3'd2, 32'h04);
        rd(3'd0, rdata); check("mode_chg_clr", rdata, 32'h0);
        rd(3'd2, rdata); check("edge_4", rdata, 32'h04);
        wr(3'd6, 32'hFF);
        rd(3'd1, rdata); check("idx6_mask", rdata, 32'h0);
        rd(3'd6, rdata); check("idx6_read", rdata, 32'h0);
        csr_a  = {4'h3, 7'd0, 3'd1};
        csr_di = 32'hFF;
        csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
        rd(3'd1, rdata); check("bank_miss_wr", rdata, 32'h0);

        irq_in = 8'h08;
        wr(3'd1, 32'h08);
        tick();
        tick();
        check("pre_rst_irq", cpu_irq, 32'h8);
        rst = 1'b1;
        tick();
        check("mid_rst_drop", cpu_irq, 32'h0);
        rst = 1'b0;
        tick();
        rd(3'd0, rdata); check("post_rst_level", rdata, 32'h08);
        rd(3'd2, rdata); check("post_rst_edge", rdata, 32'h0);
        check("post_rst_irq", cpu_irq, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
